// File: rtl/spi_defs_pkg.sv
// Shared SPI slave definitions: bus mode, byte width, default fill byte and FSM state type.
package spi_defs;

  localparam int BYTE_W = 8;

  // Mode 0: SCLK idles low, data sampled on the rising edge.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  localparam logic [BYTE_W-1:0] DEFAULT_FILL = 8'hFF;

  typedef enum logic {IDLE, SHIFT} state_t;

endpackage

// File: rtl/spi_sync.sv
// N-stage synchroniser for an asynchronous input with rise/fall detection
// taken from the last two synchronised samples.
module spi_sync #(
  parameter int   STAGES   = 2,
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              last;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {STAGES{IDLE_VAL}};
      last  <= IDLE_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      last  <= chain[STAGES-1];
    end
  end

  assign dout = chain[STAGES-1];
  assign rise = dout & ~last;
  assign fall = ~dout & last;

endmodule

// File: rtl/spi_slave.sv
// Mode 0 SPI slave: oversampled SCLK/CS/MOSI, one-deep transmit holding
// register, MSB-first receive with per-byte valid strobe.
module spi_slave
  import spi_defs::*;
#(
  parameter int                SYNC_STAGES = 2,
  parameter logic [BYTE_W-1:0] FILL_BYTE   = DEFAULT_FILL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic [BYTE_W-1:0] tx_byte,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [BYTE_W-1:0] rx_byte,
  output logic              rx_valid,
  output logic              frame_start,
  output logic              frame_end,
  output logic              tx_underrun
);

  // After reset the CS synchroniser refills from its idle value; a CS pin
  // still held low would look like a fresh falling edge, so edges are
  // ignored until the chain has been fully flushed.
  localparam int GUARD = SYNC_STAGES + 1;
  localparam int GW    = $clog2(GUARD + 1);

  state_t              state, state_next;
  logic                sclk_sync, sclk_rise, sclk_fall;
  logic                cs_sync, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_chain;
  logic                mosi_s;
  logic [GW-1:0]       guard_cnt;
  logic                guard_done;
  logic [BYTE_W-1:0]   tx_sh, hold;
  logic [BYTE_W-2:0]   rx_sh;
  logic [2:0]          bit_cnt;
  logic                byte_done, hold_full;
  logic                start_frame, stop_frame, bit_rise, bit_fall, load_tx, accept;

  spi_sync #(.STAGES(SYNC_STAGES), .IDLE_VAL(SPI_CPOL)) u_sclk_sync (
    .clk(clk), .rst(rst), .din(spi_sclk),
    .dout(sclk_sync), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .din(spi_cs_n),
    .dout(cs_sync), .rise(cs_rise), .fall(cs_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      mosi_chain <= '0;
      guard_cnt  <= '0;
      state      <= IDLE;
    end else begin
      mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], spi_mosi};
      if (!guard_done)
        guard_cnt <= guard_cnt + GW'(1);
      state <= state_next;
    end
  end

  assign mosi_s     = mosi_chain[SYNC_STAGES-1];
  assign guard_done = (guard_cnt == GW'(GUARD));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cs_fall && guard_done) state_next = SHIFT;
      SHIFT:   if (cs_rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // CS deassertion takes priority over any SCLK edge seen in the same cycle.
  assign start_frame = (state == IDLE) && (state_next == SHIFT);
  assign stop_frame  = (state == SHIFT) && cs_rise;
  assign bit_rise    = (state == SHIFT) && !cs_rise && sclk_rise && !sclk_fall && sclk_sync;
  assign bit_fall    = (state == SHIFT) && !cs_rise && sclk_fall;
  assign load_tx     = start_frame || (bit_fall && byte_done);
  assign accept      = tx_load && (!hold_full || load_tx);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_sh       <= '0;
      rx_sh       <= '0;
      hold        <= '0;
      hold_full   <= 1'b0;
      bit_cnt     <= '0;
      byte_done   <= 1'b0;
      rx_byte     <= '0;
      rx_valid    <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      tx_underrun <= 1'b0;
      spi_miso_oe <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_start <= start_frame;
      frame_end   <= stop_frame;
      spi_miso_oe <= (state_next == SHIFT);

      // A load coinciding with tx_load takes the old holding content.
      if (accept)
        hold <= tx_byte;
      hold_full <= (hold_full && !load_tx) || accept;

      if (load_tx) begin
        tx_sh       <= hold_full ? hold : FILL_BYTE;
        tx_underrun <= !hold_full;
        byte_done   <= 1'b0;
      end else if (bit_fall) begin
        tx_sh <= {tx_sh[BYTE_W-2:0], 1'b0};
      end

      if (start_frame) begin
        bit_cnt <= '0;
      end else if (bit_rise) begin
        rx_sh   <= {rx_sh[BYTE_W-3:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_byte   <= {rx_sh, mosi_s};
          rx_valid  <= 1'b1;
          byte_done <= 1'b1;
        end
      end
    end
  end

  assign spi_miso = spi_miso_oe & tx_sh[BYTE_W-1];
  assign tx_ready = !hold_full;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a Mode 0 master at clk/8 with scoreboard
// queues for bytes expected on rx_byte and on MISO.
module tb_spi_slave;

  localparam int          SYNC = 2;
  localparam logic [7:0]  FILL = 8'hFF;

  logic       clk = 1'b0;
  logic       rst;
  logic       spi_sclk, spi_cs_n, spi_mosi, spi_miso, spi_miso_oe;
  logic [7:0] tx_byte, rx_byte;
  logic       tx_load, tx_ready, rx_valid, frame_start, frame_end, tx_underrun;

  int assert_cnt = 0;
  int fail_cnt   = 0;
  int n_rx = 0, n_start = 0, n_end = 0, n_under = 0;

  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_miso_q[$];

  spi_slave #(.SYNC_STAGES(SYNC), .FILL_BYTE(FILL)) dut (
    .clk(clk), .rst(rst),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .tx_byte(tx_byte), .tx_load(tx_load), .tx_ready(tx_ready),
    .rx_byte(rx_byte), .rx_valid(rx_valid),
    .frame_start(frame_start), .frame_end(frame_end), .tx_underrun(tx_underrun)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_cnt++;
    assert (observed === expected)
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Pulse counters and receive-side scoreboard, sampled away from the active edge.
  always @(negedge clk) begin
    if (frame_start) n_start++;
    if (frame_end)   n_end++;
    if (tx_underrun) n_under++;
    if (rx_valid) begin
      n_rx++;
      if (exp_rx_q.size() == 0) check_output("rx_unexpected", rx_valid, 1'b0);
      else                      check_output("rx_byte", rx_byte, exp_rx_q.pop_front());
    end
  end

  task automatic apply_stimulus(input logic [7:0] b, input bit push);
    @(negedge clk);
    tx_byte = b;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    check_output("tx_ready_after_load", tx_ready, 1'b0);
    if (push) exp_miso_q.push_back(b);
  endtask

  task automatic cs_assert();
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_release();
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] mo, input int nbits);
    logic [7:0] mi;
    int lat;
    mi  = '0;
    lat = 99;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = mo[i];
      repeat (4) @(negedge clk);
      mi[i] = spi_miso;
      spi_sclk = 1'b1;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        if (i == 0 && rx_valid && lat == 99) lat = k;
      end
      spi_sclk = 1'b0;
    end
    if (nbits == 8) begin
      check_output("rx_latency_ok", lat <= SYNC + 2, 1'b1);
      if (exp_miso_q.size() == 0) check_output("miso_unexpected_byte", mi, 8'hxx);
      else                        check_output("miso_byte", mi, exp_miso_q.pop_front());
    end
  endtask

  initial begin
    int s_rx, s_start, s_end, s_under, oe_hi;

    rst = 1'b1; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    tx_byte = '0; tx_load = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_miso", spi_miso, 1'b0);
    check_output("rst_oe", spi_miso_oe, 1'b0);
    check_output("rst_tx_ready", tx_ready, 1'b1);
    check_output("rst_rx_byte", rx_byte, 8'h00);
    check_output("rst_pulses", {rx_valid, frame_start, frame_end, tx_underrun}, 4'b0000);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] SCLK toggling while deselected");
    s_rx = n_rx; oe_hi = 0;
    for (int t = 0; t < 8; t++) begin
      spi_sclk = ~spi_sclk;
      spi_mosi = ~spi_mosi;
      repeat (4) @(negedge clk);
      oe_hi += int'(spi_miso_oe);
    end
    check_output("idle_rx_valid", n_rx - s_rx, 0);
    check_output("idle_oe", oe_hi, 0);

    $display("[TB] single byte frame");
    apply_stimulus(8'hA5, 1'b1);
    s_rx = n_rx; s_start = n_start; s_end = n_end;
    exp_rx_q.push_back(8'h3C);
    cs_assert();
    check_output("oe_on_select", spi_miso_oe, 1'b1);
    check_output("miso_first_bit", spi_miso, 1'b1);
    spi_bits(8'h3C, 8);
    cs_release();
    check_output("one_rx_valid", n_rx - s_rx, 1);
    check_output("one_frame_start", n_start - s_start, 1);
    check_output("one_frame_end", n_end - s_end, 1);
    check_output("rx_byte_held", rx_byte, 8'h3C);
    check_output("oe_off_after_frame", spi_miso_oe, 1'b0);

    $display("[TB] three byte frame with underrun");
    apply_stimulus(8'h11, 1'b1);
    s_under = n_under;
    cs_assert();
    check_output("tx_ready_after_start", tx_ready, 1'b1);
    apply_stimulus(8'h22, 1'b1);
    exp_miso_q.push_back(FILL);
    exp_rx_q.push_back(8'h01); exp_rx_q.push_back(8'h02); exp_rx_q.push_back(8'h03);
    spi_bits(8'h01, 8);
    spi_bits(8'h02, 8);
    check_output("no_underrun_yet", n_under - s_under, 0);
    spi_bits(8'h03, 8);
    check_output("one_underrun", n_under - s_under, 1);
    cs_release();

    $display("[TB] aborted frame then full frame");
    s_rx = n_rx;
    cs_assert();
    spi_bits(8'hB7, 5);
    cs_release();
    check_output("abort_no_rx_valid", n_rx - s_rx, 0);
    check_output("abort_oe", spi_miso_oe, 1'b0);
    apply_stimulus(8'h5A, 1'b1);
    exp_rx_q.push_back(8'hC3);
    cs_assert();
    spi_bits(8'hC3, 8);
    cs_release();
    check_output("after_abort_rx_byte", rx_byte, 8'hC3);
    check_output("after_abort_rx_count", n_rx - s_rx, 1);

    $display("[TB] second load while full is dropped");
    apply_stimulus(8'h55, 1'b1);
    apply_stimulus(8'h66, 1'b0);
    exp_rx_q.push_back(8'h96);
    cs_assert();
    spi_bits(8'h96, 8);
    cs_release();

    $display("[TB] reset mid-frame");
    apply_stimulus(8'h77, 1'b0);
    cs_assert();
    spi_bits(8'hE1, 3);
    apply_stimulus(8'h88, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_output("midrst_oe", spi_miso_oe, 1'b0);
    check_output("midrst_miso", spi_miso, 1'b0);
    check_output("midrst_tx_ready", tx_ready, 1'b1);
    check_output("midrst_rx_byte", rx_byte, 8'h00);
    check_output("midrst_pulses", {rx_valid, frame_start, frame_end, tx_underrun}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    s_start = n_start;
    repeat (10) @(negedge clk);
    check_output("no_start_without_edge", n_start - s_start, 0);
    check_output("no_oe_without_edge", spi_miso_oe, 1'b0);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
    exp_miso_q.push_back(FILL);
    exp_rx_q.push_back(8'h4D);
    s_under = n_under;
    cs_assert();
    check_output("fill_after_reset_underrun", n_under - s_under, 1);
    spi_bits(8'h4D, 8);
    cs_release();

    check_output("rx_queue_drained", exp_rx_q.size(), 0);
    check_output("miso_queue_drained", exp_miso_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
